control_unit: RTL and testbench

Hard-wired sequencer that drives every control input of the datapath. It fetches instructions, decodes the opcode and register fields from the IR value the datapath returns, and steps through one control step per clock. For each supported instruction it asserts the same per-step control signals that the datapath benches apply by hand. It sits directly upstream of `datapath`, and its outputs connect one-to-one to the datapath's control ports.

---
 rtl/control_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_control_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hard-wired control sequencer for the datapath: fetch, decode, and one control step per clock.
// Control outputs are a Moore decode of the current step and the opcode and register fields of
// the IR. The IR is not registered here.
module control_unit #(
  parameter int unsigned NRegs = 16
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic [31:0]      ir_i,
  input  logic             stop_i,
  output logic             pcout_o,
  output logic             zhighout_o,
  output logic             zlowout_o,
  output logic             mdrout_o,
  output logic             hiout_o,
  output logic             loout_o,
  output logic             pcin_o,
  output logic             irin_o,
  output logic             marin_o,
  output logic             mdrin_o,
  output logic             yin_o,
  output logic             zhighin_o,
  output logic             zlowin_o,
  output logic             hiin_o,
  output logic             loin_o,
  output logic             incpc_o,
  output logic             read_o,
  output logic             cout_o,
  output logic             inport_o,
  output logic             cin_o,
  output logic             outport_o,
  output logic [4:0]       op_o,
  output logic [NRegs-1:0] r_in_o,
  output logic [NRegs-1:0] r_out_o,
  output logic             run_o,
  output logic             illegal_o
);

  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StT5   = 3'd5,
    StT6   = 3'd6,
    StHalt = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ClsThree,
    ClsUnary,
    ClsMulDiv,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } cls_e;

  state_e     state_q, state_d;
  logic       stop_pending_q, stop_pending_d;
  logic       illegal_q, illegal_d;
  logic       to_t0;
  logic       stop_now;
  cls_e       cls;
  logic [4:0] alu_op;

  logic [4:0]       opcode;
  logic [NRegs-1:0] ra_oh, rb_oh, rc_oh;

  // Low IR bits carry immediates used only by the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_i[14:0];

  function automatic logic [NRegs-1:0] onehot(input logic [3:0] idx);
    logic [NRegs-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign opcode = ir_i[31:27];
  assign ra_oh  = onehot(ir_i[26:23]);
  assign rb_oh  = onehot(ir_i[22:19]);
  assign rc_oh  = onehot(ir_i[18:15]);

  // Reserved port-I/O controls are held idle.
  assign cout_o    = 1'b0;
  assign inport_o  = 1'b0;
  assign cin_o     = 1'b0;
  assign outport_o = 1'b0;

  // Opcode decode into an instruction class and ALU operation.
  always_comb begin
    cls    = ClsIllegal;
    alu_op = 5'b00000;
    case (opcode)
      5'b00011: begin cls = ClsThree;  alu_op = 5'b00010; end
      5'b00100: begin cls = ClsThree;  alu_op = 5'b00011; end
      5'b00101: begin cls = ClsThree;  alu_op = 5'b00000; end
      5'b00110: begin cls = ClsThree;  alu_op = 5'b00001; end
      5'b00111: begin cls = ClsThree;  alu_op = 5'b00100; end
      5'b01000: begin cls = ClsThree;  alu_op = 5'b00101; end
      5'b01111: begin cls = ClsMulDiv; alu_op = 5'b01000; end
      5'b10000: begin cls = ClsMulDiv; alu_op = 5'b01001; end
      5'b10001: begin cls = ClsUnary;  alu_op = 5'b00110; end
      5'b10010: begin cls = ClsUnary;  alu_op = 5'b00111; end
      5'b11010: cls = ClsNop;
      5'b11011: cls = ClsHalt;
      default:  cls = ClsIllegal;
    endcase
  end

  // State, pending-stop and illegal-pulse registers with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q        <= StT0;
      stop_pending_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
      illegal_q      <= illegal_d;
    end
  end

  // Next-state sequencing; instruction boundaries divert to HALT when a stop is pending.
  always_comb begin
    state_d   = state_q;
    to_t0     = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      StT0: state_d = StT1;
      StT1: state_d = StT2;
      StT2: begin
        case (cls)
          ClsNop:     to_t0 = 1'b1;
          ClsIllegal: begin to_t0 = 1'b1; illegal_d = 1'b1; end
          ClsHalt:    state_d = StHalt;
          default:    state_d = StT3;
        endcase
      end
      StT3: begin
        if (cls == ClsThree || cls == ClsUnary || cls == ClsMulDiv) state_d = StT4;
        else                                                       to_t0   = 1'b1;
      end
      StT4: begin
        if (cls == ClsThree || cls == ClsMulDiv) state_d = StT5;
        else                                      to_t0   = 1'b1;
      end
      StT5: begin
        if (cls == ClsMulDiv) state_d = StT6;
        else                  to_t0   = 1'b1;
      end
      StT6:   to_t0   = 1'b1;
      StHalt: state_d = StHalt;
    endcase

    // A Stop in the boundary cycle itself is honoured at that boundary.
    stop_now = stop_pending_q | stop_i;
    if (to_t0) state_d = stop_now ? StHalt : StT0;
    stop_pending_d = (state_d == StHalt && state_q != StHalt) ? 1'b0 : stop_now;
  end

  // Moore control decode of the current step; everything is idle while Clear is high.
  always_comb begin
    pcout_o    = 1'b0;
    zhighout_o = 1'b0;
    zlowout_o  = 1'b0;
    mdrout_o   = 1'b0;
    hiout_o    = 1'b0;
    loout_o    = 1'b0;
    pcin_o     = 1'b0;
    irin_o     = 1'b0;
    marin_o    = 1'b0;
    mdrin_o    = 1'b0;
    yin_o      = 1'b0;
    zhighin_o  = 1'b0;
    zlowin_o   = 1'b0;
    hiin_o     = 1'b0;
    loin_o     = 1'b0;
    incpc_o    = 1'b0;
    read_o     = 1'b0;
    op_o       = 5'b00000;
    r_in_o     = '0;
    r_out_o    = '0;
    if (!clear_i) begin
      unique case (state_q)
        StT0: begin
          pcout_o   = 1'b1;
          marin_o   = 1'b1;
          incpc_o   = 1'b1;
          zlowin_o  = 1'b1;
          zhighin_o = 1'b1;
        end
        StT1: begin
          zlowout_o = 1'b1;
          pcin_o    = 1'b1;
          read_o    = 1'b1;
          mdrin_o   = 1'b1;
        end
        StT2: begin
          mdrout_o = 1'b1;
          irin_o   = 1'b1;
        end
        StT3: begin
          case (cls)
            ClsThree:  begin r_out_o = rb_oh; yin_o = 1'b1; end
            ClsUnary:  begin
              r_out_o   = rb_oh;
              op_o      = alu_op;
              zlowin_o  = 1'b1;
              zhighin_o = 1'b1;
            end
            ClsMulDiv: begin r_out_o = ra_oh; yin_o = 1'b1; end
            default:   ;
          endcase
        end
        StT4: begin
          case (cls)
            ClsThree: begin
              r_out_o   = rc_oh;
              op_o      = alu_op;
              zlowin_o  = 1'b1;
              zhighin_o = 1'b1;
            end
            ClsUnary: begin zlowout_o = 1'b1; r_in_o = ra_oh; end
            ClsMulDiv: begin
              r_out_o   = rb_oh;
              op_o      = alu_op;
              zlowin_o  = 1'b1;
              zhighin_o = 1'b1;
            end
            default: ;
          endcase
        end
        StT5: begin
          case (cls)
            ClsThree:  begin zlowout_o = 1'b1; r_in_o = ra_oh; end
            ClsMulDiv: begin zlowout_o = 1'b1; loin_o = 1'b1; end
            default:   ;
          endcase
        end
        StT6: begin
          if (cls == ClsMulDiv) begin
            zhighout_o = 1'b1;
            hiin_o     = 1'b1;
          end
        end
        StHalt: ;
      endcase
    end
    run_o     = clear_i | (state_q != StHalt);
    illegal_o = illegal_q & ~clear_i;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch and execute steps of several instructions and
// compares every control output against hand-computed values each cycle.
module tb_control_unit;

  logic        clk;
  logic        clear;
  logic        stop;
  logic [31:0] ir;
  logic        pcout, zhighout, zlowout, mdrout, hiout, loout;
  logic        pcin, irin, marin, mdrin, yin, zhighin, zlowin, hiin, loin;
  logic        incpc, read, cout, inport, cin, outport;
  logic [4:0]  op;
  logic [15:0] r_in, r_out;
  logic        run, illegal;
  logic [20:0] flags;

  int total = 0;
  int bad   = 0;

  // Single-bit control flags, packed in the order of the flags vector below.
  localparam logic [20:0] FPcOut    = 21'd1 << 20;
  localparam logic [20:0] FZHighOut = 21'd1 << 19;
  localparam logic [20:0] FZLowOut  = 21'd1 << 18;
  localparam logic [20:0] FMdrOut   = 21'd1 << 17;
  localparam logic [20:0] FHiOut    = 21'd1 << 16;
  localparam logic [20:0] FLoOut    = 21'd1 << 15;
  localparam logic [20:0] FPcIn     = 21'd1 << 14;
  localparam logic [20:0] FIrIn     = 21'd1 << 13;
  localparam logic [20:0] FMarIn    = 21'd1 << 12;
  localparam logic [20:0] FMdrIn    = 21'd1 << 11;
  localparam logic [20:0] FYIn      = 21'd1 << 10;
  localparam logic [20:0] FZHighIn  = 21'd1 << 9;
  localparam logic [20:0] FZLowIn   = 21'd1 << 8;
  localparam logic [20:0] FHiIn     = 21'd1 << 7;
  localparam logic [20:0] FLoIn     = 21'd1 << 6;
  localparam logic [20:0] FIncPc    = 21'd1 << 5;
  localparam logic [20:0] FRead     = 21'd1 << 4;

  localparam logic [20:0] FT0 = FPcOut | FMarIn | FIncPc | FZLowIn | FZHighIn;
  localparam logic [20:0] FT1 = FZLowOut | FPcIn | FRead | FMdrIn;
  localparam logic [20:0] FT2 = FMdrOut | FIrIn;
  localparam logic [20:0] FZ  = FZLowIn | FZHighIn;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'd0};
  endfunction

  localparam logic [31:0] IrAnd  = 32'h2891_8000;
  localparam logic [31:0] IrMul  = 32'h7A28_0000;
  localparam logic [31:0] IrHalt = 32'hD800_0000;
  localparam logic [31:0] IrIll  = 32'hF800_0000;
  localparam logic [31:0] IrNop  = 32'hD000_0000;

  assign flags = {pcout, zhighout, zlowout, mdrout, hiout, loout, pcin, irin, marin, mdrin, yin,
                  zhighin, zlowin, hiin, loin, incpc, read, cout, inport, cin, outport};

  control_unit #(.NRegs(16)) dut (
    .clock_i    (clk),
    .clear_i    (clear),
    .ir_i       (ir),
    .stop_i     (stop),
    .pcout_o    (pcout),
    .zhighout_o (zhighout),
    .zlowout_o  (zlowout),
    .mdrout_o   (mdrout),
    .hiout_o    (hiout),
    .loout_o    (loout),
    .pcin_o     (pcin),
    .irin_o     (irin),
    .marin_o    (marin),
    .mdrin_o    (mdrin),
    .yin_o      (yin),
    .zhighin_o  (zhighin),
    .zlowin_o   (zlowin),
    .hiin_o     (hiin),
    .loin_o     (loin),
    .incpc_o    (incpc),
    .read_o     (read),
    .cout_o     (cout),
    .inport_o   (inport),
    .cin_o      (cin),
    .outport_o  (outport),
    .op_o       (op),
    .r_in_o     (r_in),
    .r_out_o    (r_out),
    .run_o      (run),
    .illegal_o  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic run_e, input logic ill_e,
                     input logic [4:0] op_e, input logic [15:0] rin_e,
                     input logic [15:0] rout_e, input logic [20:0] fl_e);
    logic [59:0] exp_v, obs_v;
    #1;
    exp_v = {run_e, ill_e, op_e, rin_e, rout_e, fl_e};
    obs_v = {run, illegal, op, r_in, r_out, flags};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // Checks T1 and T2 of a fetch; the caller has already checked T0.
  task automatic fetch12(input string pfx);
    nxt(); chk({pfx, "_t1"}, 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT1);
    nxt(); chk({pfx, "_t2"}, 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT2);
  endtask

  initial begin
    clear = 1'b1;
    stop  = 1'b0;
    ir    = 32'h1234_5678;

    // Reset: idle controls with Run high, then T0 once Clear drops.
    nxt(); chk("rst_a", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    nxt(); chk("rst_b", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    nxt(); clear = 1'b0; ir = IrAnd;
    chk("rst_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);

    // and R1,R2,R3
    fetch12("and");
    nxt(); chk("and_t3", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0004, FYIn);
    nxt(); chk("and_t4", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0008, FZ);
    nxt(); chk("and_t5", 1'b1, 1'b0, 5'b00000, 16'h0002, 16'h0000, FZLowOut);

    // nop: next fetch exactly 6 cycles after the and's T0
    nxt(); ir = IrNop; chk("nop_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);
    fetch12("nop");

    // mul R4,R5
    nxt(); ir = IrMul; chk("mul_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);
    fetch12("mul");
    nxt(); chk("mul_t3", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0010, FYIn);
    nxt(); chk("mul_t4", 1'b1, 1'b0, 5'b01000, 16'h0000, 16'h0020, FZ);
    nxt(); chk("mul_t5", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0000, FZLowOut | FLoIn);
    nxt(); chk("mul_t6", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0000, FZHighOut | FHiIn);

    // neg R7,R9
    nxt(); ir = mk(5'b10001, 4'd7, 4'd9, 4'd0);
    chk("neg_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);
    fetch12("neg");
    nxt(); chk("neg_t3", 1'b1, 1'b0, 5'b00110, 16'h0000, 16'h0200, FZ);
    nxt(); chk("neg_t4", 1'b1, 1'b0, 5'b00000, 16'h0080, 16'h0000, FZLowOut);

    // Undefined opcode: behaves as nop, Illegal pulses in the following T0
    nxt(); ir = IrIll; chk("ill_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);
    fetch12("ill");
    nxt(); ir = mk(5'b00011, 4'd1, 4'd2, 4'd3);
    chk("ill_pulse", 1'b1, 1'b1, 5'b0, 16'h0, 16'h0, FT0);

    // add R1,R2,R3 with a one-cycle Stop in T4
    fetch12("add");
    nxt(); chk("add_t3", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0004, FYIn);
    nxt(); stop = 1'b1;
    chk("add_t4", 1'b1, 1'b0, 5'b00010, 16'h0000, 16'h0008, FZ);
    nxt(); stop = 1'b0;
    chk("add_t5", 1'b1, 1'b0, 5'b00000, 16'h0002, 16'h0000, FZLowOut);
    for (int i = 0; i < 3; i++) begin
      nxt(); chk("stop_halt", 1'b0, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    end

    // Clear leaves HALT
    nxt(); clear = 1'b1; chk("halt_clr", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    nxt(); clear = 1'b0; chk("post_clr_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);

    // Clear during T4 of an add aborts it; fetch restarts without any R_in
    fetch12("abt");
    nxt(); chk("abt_t3", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0004, FYIn);
    nxt(); clear = 1'b1; chk("abt_t4_clr", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    nxt(); clear = 1'b0; ir = mk(5'b00011, 4'd5, 4'd6, 4'd7);
    chk("abt_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);

    // add R5,R6,R7 with Stop arriving exactly in the boundary cycle (T5)
    fetch12("add2");
    nxt(); chk("add2_t3", 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0040, FYIn);
    nxt(); chk("add2_t4", 1'b1, 1'b0, 5'b00010, 16'h0000, 16'h0080, FZ);
    nxt(); stop = 1'b1;
    chk("add2_t5", 1'b1, 1'b0, 5'b00000, 16'h0020, 16'h0000, FZLowOut);
    nxt(); stop = 1'b0; chk("add2_halt", 1'b0, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);

    // halt instruction: HALT for 20 cycles until Clear
    nxt(); clear = 1'b1; chk("clr2", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    nxt(); clear = 1'b0; ir = IrHalt;
    chk("hlt_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);
    fetch12("hlt");
    for (int i = 0; i < 20; i++) begin
      nxt(); chk("hlt_state", 1'b0, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    end
    nxt(); clear = 1'b1; chk("hlt_clr", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, 21'h0);
    nxt(); clear = 1'b0; ir = IrNop;
    chk("resume_t0", 1'b1, 1'b0, 5'b0, 16'h0, 16'h0, FT0);
    fetch12("resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
